// File: rtl/pc_fetch_seq_if.sv
// pc_fetch_seq_if
// Groups the fetch sequencer's bus signals: PC to/from the pcplus4 adder, branch/jump
// redirect, decode stall, instruction-memory handshake and the decode-side instruction.
//   slave  : the sequencer (pc_fetch_seq)
//   master : the surrounding pipeline / memory model
// Optional macro PC_MISALIGN_TRAP_EN adds the misalign_trap signal.
interface pc_fetch_seq_if;
    logic [31:0] NexttoPc;
    logic [31:0] fromPc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        stall;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        fetch_err;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_trap;

    modport slave (
        input  NexttoPc, redirect_valid, redirect_target, stall, imem_ready, imem_rdata,
        output fromPc, imem_req, instr_out, instr_valid, fetch_err, misalign_trap
    );
    modport master (
        output NexttoPc, redirect_valid, redirect_target, stall, imem_ready, imem_rdata,
        input  fromPc, imem_req, instr_out, instr_valid, fetch_err, misalign_trap
    );
`else
    modport slave (
        input  NexttoPc, redirect_valid, redirect_target, stall, imem_ready, imem_rdata,
        output fromPc, imem_req, instr_out, instr_valid, fetch_err
    );
    modport master (
        output NexttoPc, redirect_valid, redirect_target, stall, imem_ready, imem_rdata,
        input  fromPc, imem_req, instr_out, instr_valid, fetch_err
    );
`endif
endinterface

// File: rtl/pc_fetch_seq.sv
// pc_fetch_seq
// Program-counter register and instruction-fetch sequencer.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : pc_fetch_seq_if.slave
//          NexttoPc in (fromPc+4 from pcplus4), fromPc out (PC / imem address),
//          redirect_valid/redirect_target in, stall in, imem_req out,
//          imem_ready/imem_rdata in, instr_out/instr_valid out, fetch_err out (1-cycle pulse),
//          misalign_trap out (1-cycle pulse, only with PC_MISALIGN_TRAP_EN).
// Parameters: RESET_VECTOR (PC after reset), TIMEOUT (2..255, cycles an unanswered request
// may wait before fetch_err).
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirects are rejected and trapped instead
// of having their low two target bits cleared.
module pc_fetch_seq #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned TIMEOUT      = 16
) (
    input logic          clk,
    input logic          rst,
    pc_fetch_seq_if.slave bus
);

    localparam logic [31:0] Nop         = 32'h0000_0013;
    localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

    state_e      stateQ, stateD;
    logic [31:0] pcQ, pcD;
    logic [31:0] instrQ, instrD;
    logic        validQ, validD;
    logic [7:0]  cntQ, cntD;
    logic        errQ, errD;
    logic        redirOk;
    logic [31:0] redirTarget;

    // Low bits are cleared unconditionally; with the trap enabled only aligned
    // targets ever get here, so the mask is a no-op in that build.
    assign redirTarget = bus.redirect_target & ~32'h3;

`ifdef PC_MISALIGN_TRAP_EN
    logic trapQ, trapD;
    assign redirOk           = (bus.redirect_target[1:0] == 2'b00);
    assign bus.misalign_trap = trapQ;
`else
    assign redirOk = 1'b1;
`endif

    always_comb begin
        stateD = stateQ;
        pcD    = pcQ;
        instrD = instrQ;
        validD = validQ;
        cntD   = cntQ;
        errD   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        trapD  = 1'b0;
`endif
        unique case (stateQ)
            StBoot: stateD = StFetch;
            StFetch, StHold: begin
                if (bus.redirect_valid) begin
                    // Redirect beats stall, a same-cycle imem_ready and a timeout.
                    if (redirOk) begin
                        pcD    = redirTarget;
                        validD = 1'b0;
                        cntD   = 8'd0;
                        stateD = StFetch;
                    end
`ifdef PC_MISALIGN_TRAP_EN
                    else begin
                        // Rejected redirect: the whole sequencer holds for this cycle.
                        trapD = 1'b1;
                    end
`endif
                end else if (stateQ == StHold) begin
                    if (!bus.stall) begin
                        pcD    = bus.NexttoPc;
                        validD = 1'b0;
                        stateD = StFetch;
                    end
                end else if (bus.imem_ready) begin
                    instrD = bus.imem_rdata;
                    validD = 1'b1;
                    cntD   = 8'd0;
                    stateD = StHold;
                end else if (cntQ == TimeoutLast) begin
                    // Give up on this attempt and re-issue the same PC.
                    errD = 1'b1;
                    cntD = 8'd0;
                end else begin
                    cntD = cntQ + 8'd1;
                end
            end
            default: stateD = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StBoot;
            pcQ    <= RESET_VECTOR;
            instrQ <= Nop;
            validQ <= 1'b0;
            cntQ   <= 8'd0;
            errQ   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            trapQ  <= 1'b0;
`endif
        end else begin
            stateQ <= stateD;
            pcQ    <= pcD;
            instrQ <= instrD;
            validQ <= validD;
            cntQ   <= cntD;
            errQ   <= errD;
`ifdef PC_MISALIGN_TRAP_EN
            trapQ  <= trapD;
`endif
        end
    end

    assign bus.fromPc      = pcQ;
    assign bus.imem_req    = (stateQ == StFetch);
    assign bus.instr_out   = instrQ;
    assign bus.instr_valid = validQ;
    assign bus.fetch_err   = errQ;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb_pc_fetch_seq
// Scoreboard bench for pc_fetch_seq: the stimulus process drives one cycle of inputs,
// advances a behavioural model and queues the expected post-edge outputs; a monitor
// process pops and compares after every rising edge, and separately checks each newly
// presented instruction against a queue of expected deliveries.
module tb_pc_fetch_seq;

    localparam logic [31:0] Rv  = 32'h0000_0000;
    localparam int          Tmo = 16;
    localparam logic [31:0] Nop = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_fetch_seq_if bus ();
    // pcplus4 adder
    assign bus.NexttoPc = bus.fromPc + 32'd4;

    pc_fetch_seq #(.RESET_VECTOR(Rv), .TIMEOUT(Tmo)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] pc;
        logic        req;
        logic        valid;
        logic [31:0] instr;
        logic        err;
        logic        trap;
    } exp_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } deliv_t;

    exp_t   expQ[$];
    deliv_t delivQ[$];
    int     checks   = 0;
    int     failures = 0;

    // Model: where the sequencer is in its life cycle, plus architectural values.
    bit          mBooting, mHolding, mValid;
    logic [31:0] mPc, mInstr;
    int          mWaited;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit st, input bit rv, input logic [31:0] rt,
                             input bit rdy, input logic [31:0] rd);
        bit err  = 1'b0;
        bit trap = 1'b0;
        bit misal = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        misal = (rt[1:0] != 2'b00);
`endif
        if (r) begin
            mBooting = 1'b1; mHolding = 1'b0; mPc = Rv; mInstr = Nop; mValid = 1'b0;
            mWaited = 0;
        end else if (mBooting) begin
            mBooting = 1'b0;
        end else if (rv && misal) begin
            trap = 1'b1;
        end else if (rv) begin
            mPc = rt & ~32'h3; mValid = 1'b0; mWaited = 0; mHolding = 1'b0;
        end else if (mHolding) begin
            if (!st) begin
                mPc = mPc + 32'd4; mValid = 1'b0; mHolding = 1'b0;
            end
        end else if (rdy) begin
            mInstr = rd; mValid = 1'b1; mHolding = 1'b1; mWaited = 0;
            delivQ.push_back('{pc: mPc, instr: rd});
        end else begin
            mWaited++;
            if (mWaited == Tmo) begin
                err = 1'b1; mWaited = 0;
            end
        end
        expQ.push_back('{pc: mPc, req: !mBooting && !mHolding, valid: mValid, instr: mInstr,
                         err: err, trap: trap});
    endtask

    task automatic drive(input bit r, input bit st, input bit rv, input logic [31:0] rt,
                         input bit rdy, input logic [31:0] rd);
        @(negedge clk);
        rst                 = r;
        bus.stall           = st;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.imem_ready      = rdy;
        bus.imem_rdata      = rd;
        modelStep(r, st, rv, rt, rdy, rd);
    endtask

    // Monitor
    logic prevValid = 1'b0;
    always @(posedge clk) begin
        exp_t   e;
        deliv_t d;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("fromPc", bus.fromPc, e.pc);
            chk("imem_req", 32'(bus.imem_req), 32'(e.req));
            chk("instr_valid", 32'(bus.instr_valid), 32'(e.valid));
            chk("instr_out", bus.instr_out, e.instr);
            chk("fetch_err", 32'(bus.fetch_err), 32'(e.err));
`ifdef PC_MISALIGN_TRAP_EN
            chk("misalign_trap", 32'(bus.misalign_trap), 32'(e.trap));
`endif
        end
        if (bus.instr_valid === 1'b1 && prevValid !== 1'b1) begin
            if (delivQ.size() == 0) begin
                chk("unexpected_delivery", bus.instr_out, 32'hxxxx_xxxx);
            end else begin
                d = delivQ.pop_front();
                chk("deliv_instr", bus.instr_out, d.instr);
                chk("deliv_pc", bus.fromPc, d.pc);
            end
        end
        prevValid = bus.instr_valid;
    end

    initial begin
        logic [31:0] rt, rd;
        int          readyMode;
        bit          r, st, rv, rdy;

        rst = 1'b1; bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
        bus.imem_ready = 1'b0; bus.imem_rdata = '0;

        // Reset, then zero-wait memory: PCs 0,4,8; stall 3 cycles holding 0x00500093.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h1111_0001);   // BOOT
        drive(0, 0, 0, 0, 1, 32'h1111_0002);   // FETCH 0
        drive(0, 0, 0, 0, 1, 32'h1111_0003);   // HOLD
        drive(0, 0, 0, 0, 1, 32'h1111_0004);   // FETCH 4
        drive(0, 0, 0, 0, 1, 32'h1111_0005);   // HOLD
        drive(0, 0, 0, 0, 1, 32'h0050_0093);   // FETCH 8
        drive(0, 1, 0, 0, 1, 32'h2222_0000);   // HOLD, stalled
        drive(0, 1, 0, 0, 1, 32'h2222_0001);
        drive(0, 1, 0, 0, 1, 32'h2222_0002);
        drive(0, 0, 0, 0, 1, 32'h2222_0003);   // leave HOLD -> 0xC
        // Redirect in FETCH with same-cycle ready: data discarded.
        drive(0, 0, 1, 32'h0000_0100, 1, 32'hDEAD_BEEF);
        drive(0, 0, 0, 0, 1, 32'h3333_0100);   // FETCH 0x100
        drive(0, 0, 0, 0, 0, 0);               // HOLD -> 0x104
        // Timeout: 20 unanswered cycles.
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h4444_0104);
        // Wrap-around.
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h5555_FFFC);
        drive(0, 0, 0, 0, 0, 0);               // HOLD -> 0x0
        drive(0, 0, 0, 0, 1, 32'h5555_0000);
        // Misaligned redirect (in HOLD).
        drive(0, 0, 1, 32'h0000_0102, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h6666_0000);
        drive(0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        readyMode = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) readyMode = $urandom_range(0, 3);
            r   = ($urandom_range(0, 199) == 0);
            st  = ($urandom_range(0, 2) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            rt  = $urandom;
            if ($urandom_range(0, 3) != 0) rt = rt & ~32'h3;
            rdy = (readyMode == 0) ? 1'b0 : ($urandom_range(0, readyMode) != 0);
            rd  = $urandom;
            drive(r, st, rv, rt, rdy, rd);
        end

        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("expq_drained", 32'(expQ.size()), 32'd0);
        chk("delivq_drained", 32'(delivQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_seq.md
Name: pc_fetch_seq

Overview:
Program-counter register and instruction-fetch sequencer. It drives the current PC (fromPc) to the pcplus4 adder and to instruction memory, and consumes the adder's NexttoPc result. It also accepts branch/jump redirects and holds fetched instructions under decode stall. It handshakes with instruction memory, whose latency is variable, and flags fetches that time out.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles imem_req may stay unanswered before fetch_err; legal range 2..255

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
NexttoPc  input  32  sequential next PC from pcplus4 (fromPc+4)
fromPc  output  32  current PC; to pcplus4 and imem address
redirect_valid  input  1  taken branch/jump this cycle
redirect_target  input  32  redirect destination PC
stall  input  1  decode cannot accept instr this cycle
imem_req  output  1  fetch request, address = fromPc
imem_ready  input  1  imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
instr_out  output  32  instruction presented to decode
instr_valid  output  1  instr_out valid
fetch_err  output  1  one-cycle pulse on fetch timeout
misalign_trap  output  1  one-cycle pulse; present only with PC_MISALIGN_TRAP_EN

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high, sampled on the rising edge.
- Reset values: fromPc=RESET_VECTOR, instr_out=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, fetch_err=0, misalign_trap=0, wait counter=0, state=BOOT.
- Reset mid-fetch: any outstanding request is abandoned; an imem_ready in the reset cycle is ignored.
- States and transitions:
  - BOOT: one cycle after rst deasserts; imem_req=0; go to FETCH.
  - FETCH: imem_req=1 (combinational from state), address=fromPc.
    - On imem_ready=1: instr_out<=imem_rdata, instr_valid<=1, go to HOLD. Fetch latency is 1 cycle minimum (ready in the first FETCH cycle).
    - Otherwise the wait counter increments. When the counter reaches TIMEOUT-1 without ready: fetch_err pulses 1 cycle, counter clears, stay in FETCH and retry the same PC.
  - HOLD: imem_req=0, instr_valid=1.
    - stall=1: instr_out and fromPc held.
    - stall=0: fromPc<=NexttoPc, instr_valid<=0, go to FETCH.
    - Net throughput with zero-wait memory: one instruction per 2 cycles.
- Redirect (highest priority, evaluated in FETCH and HOLD, overrides stall):
  - fromPc<=redirect_target; instr_valid<=0; counter clears; go to FETCH.
  - imem_ready in the same cycle is discarded; instr_out is not updated.
  - Redirect in BOOT is ignored.
- Simultaneous redirect+timeout: redirect wins; fetch_err is not pulsed.
- Wrap-around: NexttoPc=32'h0000_0000 after fromPc=32'hFFFF_FFFC is accepted as-is. No special handling.
- fromPc changes only on reset, on redirect, or on leaving HOLD with stall=0.

Optional Feature:
PC_MISALIGN_TRAP_EN:
- Defined:
  - Port misalign_trap exists.
  - A redirect with redirect_target[1:0]!=0 is rejected: fromPc, state and instr_valid are unchanged, and misalign_trap pulses 1 cycle.
  - An aligned redirect behaves as specified above.
- Undefined:
  - Port is absent.
  - redirect_target[1:0] is forced to 2'b00 and the redirect is taken normally.

Test Plan:
- Reset then zero-wait memory: rst 1 cycle, RESET_VECTOR=0, imem_ready=1 each FETCH cycle.
  -> fromPc sequence 0,4,8 (each held 2 cycles).
  -> instr_valid high every second cycle, carrying the matching imem_rdata.
- Stall in HOLD: stall=1 for 3 cycles while instr_out=32'h00500093.
  -> instr_valid and instr_out held 3 cycles, fromPc stays 0x8.
  -> When stall drops, fromPc=0xC next cycle.
- Redirect during FETCH with same-cycle imem_ready: redirect_target=0x100.
  -> instr_valid stays 0, fromPc=0x100, next imem_req addresses 0x100.
- Timeout: imem_ready held 0 for 20 cycles, TIMEOUT=16.
  -> fetch_err pulses once, 16 cycles after FETCH entry; imem_req stays 1; fromPc unchanged.
- Wrap: fromPc=0xFFFFFFFC, stall=0.
  -> fromPc=0x00000000 after HOLD.
- Misaligned redirect to 0x102.
  -> Macro defined: misalign_trap pulse, fromPc unchanged.
  -> Macro undefined: fromPc=0x100.
